axi_4_lite_regbank: RTL

AXI_4_LITE_REGBANK -- requirements
Module: axi_4_lite_regbank

---
 rtl/axi_4_lite_regbank.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/axi_4_lite_regbank.sv
// rtl/axi_4_lite_regbank.sv - AXI4-Lite slave register bank with read-only HW inputs and access strobes
module axi_4_lite_regbank #(
   parameter int           C_AXI_DATA_WIDTH   = 32,
   parameter int           C_AXI_ADDR_WIDTH   = 8,
   parameter int           C_REGISTERS_NUMBER = 16,
   parameter logic [255:0] C_RO_MASK          = '0
) (
   input  logic                                         S_AXI_ACLK,
   input  logic                                         S_AXI_ARESET,
   input  logic                                         S_AXI_AWVALID,
   output logic                                         S_AXI_AWREADY,
   input  logic [C_AXI_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
   input  logic [2:0]                                   S_AXI_AWPROT,
   input  logic                                         S_AXI_WVALID,
   output logic                                         S_AXI_WREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0]                  S_AXI_WDATA,
   input  logic [C_AXI_DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
   output logic                                         S_AXI_BVALID,
   input  logic                                         S_AXI_BREADY,
   output logic [1:0]                                   S_AXI_BRESP,
   input  logic                                         S_AXI_ARVALID,
   output logic                                         S_AXI_ARREADY,
   input  logic [C_AXI_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
   input  logic [2:0]                                   S_AXI_ARPROT,
   output logic                                         S_AXI_RVALID,
   input  logic                                         S_AXI_RREADY,
   output logic [C_AXI_DATA_WIDTH-1:0]                  S_AXI_RDATA,
   output logic [1:0]                                   S_AXI_RRESP,
   output logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] REG_OUT,
   input  logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] HW_IN,
   output logic [C_REGISTERS_NUMBER-1:0]                WR_PULSE,
   output logic [C_REGISTERS_NUMBER-1:0]                RD_PULSE
);
   localparam int DW       = C_AXI_DATA_WIDTH;
   localparam int NUM      = C_REGISTERS_NUMBER;
   localparam int SW       = DW / 8;
   localparam int ADDR_LSB = $clog2(SW);
   localparam int IW       = C_AXI_ADDR_WIDTH - ADDR_LSB;

   localparam logic [1:0] W_IDLE      = 2'd0;
   localparam logic [1:0] W_ADDR_HELD = 2'd1;
   localparam logic [1:0] W_DATA_HELD = 2'd2;
   localparam logic [1:0] W_RESP      = 2'd3;

   logic [1:0]     w_state;
   logic [IW-1:0]  aw_idx_q;
   logic [DW-1:0]  w_data_q;
   logic [SW-1:0]  w_strb_q;
   logic [1:0]     bresp_q;
   logic [DW-1:0]  regs [NUM];

   logic           commit;
   logic [IW-1:0]  c_idx;
   logic [DW-1:0]  c_data;
   logic [SW-1:0]  c_strb;
   logic [NUM-1:0] wr_hit;

   logic           rvalid_q;
   logic [DW-1:0]  rdata_q;
   logic [1:0]     rresp_q;
   logic [IW-1:0]  ar_idx;
   logic [NUM-1:0] rd_sel;
   logic [DW-1:0]  rd_data_n;
   logic           ar_hs;

   assign S_AXI_AWREADY = (w_state == W_IDLE) || (w_state == W_DATA_HELD);
   assign S_AXI_WREADY  = (w_state == W_IDLE) || (w_state == W_ADDR_HELD);
   assign S_AXI_BVALID  = (w_state == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = !rvalid_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;

   // The write commits on whichever handshake completes the address/data pair.
   always_comb begin
      commit = 1'b0;
      c_idx  = S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
      c_data = S_AXI_WDATA;
      c_strb = S_AXI_WSTRB;
      case (w_state)
         W_IDLE:      commit = S_AXI_AWVALID && S_AXI_WVALID;
         W_ADDR_HELD: begin
            commit = S_AXI_WVALID;
            c_idx  = aw_idx_q;
         end
         W_DATA_HELD: begin
            commit = S_AXI_AWVALID;
            c_data = w_data_q;
            c_strb = w_strb_q;
         end
         default: commit = 1'b0;
      endcase
   end

   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < NUM; i++) begin
         if (c_idx == IW'(i) && !C_RO_MASK[i]) wr_hit[i] = 1'b1;
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         w_state  <= W_IDLE;
         aw_idx_q <= '0;
         w_data_q <= '0;
         w_strb_q <= '0;
         bresp_q  <= 2'b00;
         WR_PULSE <= '0;
         for (int i = 0; i < NUM; i++) regs[i] <= '0;
      end else begin
         WR_PULSE <= '0;
         case (w_state)
            W_IDLE: begin
               if (commit) begin
                  w_state <= W_RESP;
               end else if (S_AXI_AWVALID) begin
                  w_state  <= W_ADDR_HELD;
                  aw_idx_q <= S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
               end else if (S_AXI_WVALID) begin
                  w_state  <= W_DATA_HELD;
                  w_data_q <= S_AXI_WDATA;
                  w_strb_q <= S_AXI_WSTRB;
               end
            end
            W_ADDR_HELD, W_DATA_HELD: if (commit) w_state <= W_RESP;
            W_RESP:                   if (S_AXI_BREADY) w_state <= W_IDLE;
            default:                  w_state <= W_IDLE;
         endcase
         if (commit) begin
            bresp_q  <= (|wr_hit) ? 2'b00 : 2'b10;
            WR_PULSE <= wr_hit;
            for (int i = 0; i < NUM; i++) begin
               for (int j = 0; j < SW; j++) begin
                  if (wr_hit[i] && c_strb[j]) regs[i][j*8 +: 8] <= c_data[j*8 +: 8];
               end
            end
         end
      end
   end

   assign ar_idx = S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
   assign ar_hs  = S_AXI_ARVALID && !rvalid_q;

   // Read-only registers return the live hardware value, sampled at the AR handshake.
   always_comb begin
      rd_sel    = '0;
      rd_data_n = '0;
      for (int i = 0; i < NUM; i++) begin
         if (ar_idx == IW'(i)) begin
            rd_sel[i] = 1'b1;
            rd_data_n = C_RO_MASK[i] ? HW_IN[i*DW +: DW] : regs[i];
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= 2'b00;
         RD_PULSE <= '0;
      end else begin
         RD_PULSE <= '0;
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_n;
            rresp_q  <= (|rd_sel) ? 2'b00 : 2'b10;
            RD_PULSE <= rd_sel;
         end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM; g++) begin : g_reg_out
      assign REG_OUT[g*DW +: DW] = regs[g];
   end

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                        S_AXI_ARADDR[ADDR_LSB-1:0], HW_IN};
endmodule
